// File: rtl/lfsr_pkg.sv
// Shared constants and the feedback helper for the 16-bit Fibonacci LFSR.
package lfsr_pkg;

    localparam int          LFSR_WIDTH = 16;
    localparam logic [15:0] LFSR_TAPS  = 16'h002D;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    // Parity of the tapped state bits, mixed with the external entropy bit.
    function automatic logic lfsr_feedback(
        input logic [LFSR_WIDTH-1:0] state,
        input logic [LFSR_WIDTH-1:0] taps,
        input logic                  rnd
    );
        lfsr_feedback = (^(state & taps)) ^ rnd;
    endfunction

endpackage : lfsr_pkg

// File: rtl/lfsr.sv
// 16-bit Fibonacci LFSR: shifts right every clock, the XOR of the tapped
// bits (and the external random bit) enters the MSB. State comes straight
// from flops.
// Optional build macro LFSR_LOCKUP_RECOVERY_EN: when defined, an all-zero
// state reloads SEED on the next non-reset edge instead of shifting.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int                     WIDTH = LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0]  TAPS  = LFSR_TAPS,
    parameter logic [LFSR_WIDTH-1:0]  SEED  = LFSR_SEED
) (
    input  logic             clk,
    input  logic             random,
    output logic [WIDTH-1:0] shiftreg,
    input  logic             rst
);

    logic [WIDTH-1:0] shiftreg_q;
    logic [WIDTH-1:0] shiftreg_d;
    logic             fb_s;

    // Next-state: shift right with the feedback bit entering at the MSB.
    always_comb begin
        fb_s       = lfsr_feedback(shiftreg_q, TAPS, random);
        shiftreg_d = {fb_s, shiftreg_q[WIDTH-1:1]};
`ifdef LFSR_LOCKUP_RECOVERY_EN
        if (shiftreg_q == {WIDTH{1'b0}}) begin
            shiftreg_d = SEED;
        end else begin
            shiftreg_d = {fb_s, shiftreg_q[WIDTH-1:1]};
        end
`endif
    end

    // State register; synchronous reset reloads the seed with top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftreg_q <= SEED;
        end else begin
            shiftreg_q <= shiftreg_d;
        end
    end

    assign shiftreg = shiftreg_q;

endmodule : lfsr

// File: tb/tb_lfsr.sv
// Directed self-checking bench for lfsr. Expected values are spec constants
// or come from a small independent reference model of the shift rule.
module tb_lfsr;

    logic        clk;
    logic        rst;
    logic        random;
    logic [15:0] shiftreg;

    int total_cnt = 0;
    int bad_cnt   = 0;

    lfsr dut (
        .clk      (clk),
        .random   (random),
        .shiftreg (shiftreg),
        .rst      (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of one non-reset step.
    function automatic logic [15:0] ref_next(input logic [15:0] s, input logic r);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5] ^ r;
        return {fb, s[15:1]};
    endfunction

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r_rst, input logic r_rnd);
        @(negedge clk);
        rst    = r_rst;
        random = r_rnd;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] model;
    logic        want;
    int          seed_seen;

    initial begin
        rst    = 1'b1;
        random = 1'b0;

        // Reset with random=0.
        step(1'b1, 1'b0);
        chk("reset_seed", {16'h0, shiftreg}, 32'h0000_ACE1);
        // Reset wins over random=1.
        step(1'b1, 1'b1);
        chk("reset_priority", {16'h0, shiftreg}, 32'h0000_ACE1);

        // First step after release.
        step(1'b0, 1'b0);
        chk("first_step", {16'h0, shiftreg}, 32'h0000_5670);

        // Entropy bit inverts the feedback.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("entropy_step", {16'h0, shiftreg}, 32'h0000_D670);

        // Long run from reset, random=0, against the reference model.
        step(1'b1, 1'b0);
        model     = 16'hACE1;
        seed_seen = 0;
        for (int i = 1; i <= 1001; i++) begin
            step(1'b0, 1'b0);
            model = ref_next(model, 1'b0);
            if (shiftreg !== model) begin
                chk($sformatf("long_step_%0d", i), {16'h0, shiftreg}, {16'h0, model});
            end else begin
                total_cnt++;
            end
            if (shiftreg == 16'hACE1) seed_seen++;
            if (i == 1000) chk("step_1000", {16'h0, shiftreg}, 32'h0000_7CB9);
        end
        chk("seed_no_recur", seed_seen, 32'd0);

        // Mid-run reset and resume.
        step(1'b1, 1'b1);
        chk("midrun_reset", {16'h0, shiftreg}, 32'h0000_ACE1);
        step(1'b0, 1'b0);
        chk("resume_step", {16'h0, shiftreg}, 32'h0000_5670);

        // Steer the state to 0x0001: a 1 enters first, then fifteen 0s.
        model = 16'h5670;
        for (int i = 0; i < 16; i++) begin
            want = (i == 0) ? 1'b1 : 1'b0;
            step(1'b0, model[0] ^ model[2] ^ model[3] ^ model[5] ^ want);
            model = {want, model[15:1]};
        end
        chk("steer_0001", {16'h0, shiftreg}, 32'h0000_0001);

        // random=1 from 0x0001 reaches all-zero.
        step(1'b0, 1'b1);
        chk("reach_zero", {16'h0, shiftreg}, 32'h0000_0000);

        // Behaviour from the all-zero state.
        step(1'b0, 1'b0);
`ifdef LFSR_LOCKUP_RECOVERY_EN
        chk("lockup_recover", {16'h0, shiftreg}, 32'h0000_ACE1);
        step(1'b0, 1'b0);
        chk("post_recover", {16'h0, shiftreg}, 32'h0000_5670);
`else
        chk("lockup_hold", {16'h0, shiftreg}, 32'h0000_0000);
        step(1'b0, 1'b0);
        chk("lockup_hold2", {16'h0, shiftreg}, 32'h0000_0000);
        step(1'b0, 1'b1);
        chk("lockup_exit", {16'h0, shiftreg}, 32'h0000_8000);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_lfsr
